// File: rtl/mul_arbiter.sv
// ---------------------------------------------------------------------------
// MulArbiter (module mul_arbiter)
//
// Purpose:
//   Shares one 32x32 signed multiplier between two requesters.  Only one
//   operation is in flight at a time.  A requester presents an operand pair
//   with a valid/ready handshake; the arbiter picks a winner, computes the
//   exact 64-bit signed product and hands it back on that requester's
//   response channel, holding it stable until the requester takes it.
//
//   Contended grants alternate between the two requesters.  The very first
//   contended grant after reset goes to the requester selected by PRIO.
//
// Configuration:
//   MUL_ARB_PIPE_EN  When defined, the multiply is split over two cycles
//                    (CALC registers two partial products, CALC2 sums them),
//                    adding one cycle of latency.  When undefined, the full
//                    product is formed and registered in CALC.
//
// Parameters:
//   PRIO        requester id (0 or 1) that wins the first contended grant
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous active-high reset
//   req0_valid  requester 0 has an operand pair pending
//   req0_ready  requester 0 operand pair accepted this cycle
//   req0_a/b    requester 0 signed 32-bit operands
//   req1_*      same for requester 1
//   rsp0_valid  product for requester 0 is presented
//   rsp0_ready  requester 0 consumes its product
//   rsp0_prod   signed 64-bit product for requester 0 (0 when not presented)
//   rsp1_*      same for requester 1
//   busy        high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module mul_arbiter #(
    parameter int PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [63:0] rsp0_prod,

    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [63:0] rsp1_prod,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        RESP  = 2'd2,
        CALC2 = 2'd3
    } state_t;

    // Requester id that must win the first contended grant after reset.
    localparam logic PRIO_ID = (PRIO != 0);

    state_t      state;
    state_t      state_nxt;

    logic        last_grant;
    logic        cur_id;
    logic        grant_id;
    logic        accept;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [63:0] result;
    logic [63:0] a_ext;

    // Sign-extending both operands to 64 bits and keeping the low 64 bits of
    // the unsigned product gives the exact two's-complement signed product,
    // including the -2^31 x -2^31 corner.
    assign a_ext = {{32{op_a[31]}}, op_a};

`ifdef MUL_ARB_PIPE_EN
    // Split b into an unsigned low half and a signed high half:
    //   b = b_hi * 2^16 + b_lo
    // so a*b = a*b_lo + (a*b_hi << 16), all modulo 2^64.
    logic [63:0] part_lo;
    logic [63:0] part_hi;
    logic [63:0] part_lo_nxt;
    logic [63:0] part_hi_nxt;

    assign part_lo_nxt = a_ext * {48'd0, op_b[15:0]};
    assign part_hi_nxt = a_ext * {{48{op_b[31]}}, op_b[31:16]};
`else
    logic [63:0] b_ext;
    logic [63:0] product;

    assign b_ext   = {{32{op_b[31]}}, op_b};
    assign product = a_ext * b_ext;
`endif

    // Grant selection: a lone requester always wins; when both are valid the
    // one that was not granted last wins.  Reset loads last_grant with the
    // opposite of PRIO so that PRIO takes the first contended grant.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1_valid;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.  The request readies are only ever
    // raised in IDLE for the granted requester; they are additionally masked
    // by rst because the state register is IDLE throughout reset and the
    // handshake must stay quiet until reset is released.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;

        case (state)
            IDLE: begin
                accept     = !rst && (grant_id ? req1_valid : req0_valid);
                req0_ready = accept && !grant_id;
                req1_ready = accept &&  grant_id;
                if (accept) begin
                    state_nxt = CALC;
                end
            end

            CALC: begin
`ifdef MUL_ARB_PIPE_EN
                state_nxt = CALC2;
`else
                state_nxt = RESP;
`endif
            end

            CALC2: begin
`ifdef MUL_ARB_PIPE_EN
                state_nxt = RESP;
`else
                state_nxt = IDLE;
`endif
            end

            RESP: begin
                rsp0_valid = !cur_id;
                rsp1_valid =  cur_id;
                if (cur_id ? rsp1_ready : rsp0_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, grant bookkeeping and the multiply datapath.  Operands
    // and the requester id are latched on accept; the product is registered
    // while in CALC (or built from partial products across CALC/CALC2).  The
    // result register is only ever read while in RESP, so it needs no
    // explicit clear between operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a       <= '0;
            op_b       <= '0;
            cur_id     <= 1'b0;
            last_grant <= ~PRIO_ID;
            result     <= '0;
`ifdef MUL_ARB_PIPE_EN
            part_lo    <= '0;
            part_hi    <= '0;
`endif
        end else begin
            if (accept) begin
                op_a       <= grant_id ? req1_a : req0_a;
                op_b       <= grant_id ? req1_b : req0_b;
                cur_id     <= grant_id;
                last_grant <= grant_id;
            end
`ifdef MUL_ARB_PIPE_EN
            if (state == CALC) begin
                part_lo <= part_lo_nxt;
                part_hi <= part_hi_nxt;
            end
            if (state == CALC2) begin
                result <= part_lo + (part_hi << 16);
            end
`else
            if (state == CALC) begin
                result <= product;
            end
`endif
        end
    end

    // Products are only driven on the channel that currently holds a valid
    // response; the other channel reads as zero.
    assign rsp0_prod = rsp0_valid ? result : 64'd0;
    assign rsp1_prod = rsp1_valid ? result : 64'd0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mul_arbiter
//
// Scoreboard bench for mul_arbiter.  Drivers push the expected product of each
// issued operand pair into a per-requester queue.  An independent monitor
// keeps a cycle-level reference of the arbiter (free/in-flight, grant
// pointer, age since accept) and on every cycle compares readies, response
// valids, busy and products against it, popping the queue when a response
// transfer completes.  Honours MUL_ARB_PIPE_EN for the expected latency.
// ---------------------------------------------------------------------------
module tb_mul_arbiter;

    localparam int PRIO = 0;
    localparam bit PRIO_ID = (PRIO != 0);
`ifdef MUL_ARB_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [31:0] req0_a = '0;
    logic [31:0] req0_b = '0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [31:0] req1_a = '0;
    logic [31:0] req1_b = '0;

    logic        rsp0_valid;
    logic        rsp0_ready = 1'b1;
    logic [63:0] rsp0_prod;
    logic        rsp1_valid;
    logic        rsp1_ready = 1'b1;
    logic [63:0] rsp1_prod;
    logic        busy;

    int          nCompared = 0;
    int          nMismatch = 0;

    logic [63:0] expq0[$];
    logic [63:0] expq1[$];
    int          grantLog[$];

    bit          rdyRandom = 1'b0;
    bit          rdyForce0 = 1'b1;
    bit          rdyForce1 = 1'b1;

    mul_arbiter #(.PRIO(PRIO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_prod  (rsp0_prod),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_prod  (rsp1_prod),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        nCompared++;
        nMismatch++;
        $display("[TB] FAIL %s: actual timeout required event", name);
    endtask

    function automatic logic rdyOf(input int n);
        return (n == 0) ? req0_ready : req1_ready;
    endfunction

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h0000_0001;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Issue one operand pair on requester n after 'gap' idle cycles and
    // return at the rising edge on which it is accepted (valid stays high
    // until the next call or releaseReq).
    task automatic applyStimulus(input int n, input logic [31:0] a, input logic [31:0] b, input int gap);
        int w;
        longint pa;
        longint pb;
        @(negedge clk);
        if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        repeat (gap) @(negedge clk);
        if (n == 0) begin
            req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        w = 0;
        #1;
        while (!rdyOf(n)) begin
            w++;
            if (w > 500) begin
                failNow((n == 0) ? "req0_accept_timeout" : "req1_accept_timeout");
                if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        if (n == 0) expq0.push_back(64'(pa * pb)); else expq1.push_back(64'(pa * pb));
        grantLog.push_back(n);
        @(posedge clk);
    endtask

    task automatic releaseReq(input int n);
        @(negedge clk);
        if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int w;
        w = 0;
        @(negedge clk);
        #2;
        while (busy || expq0.size() != 0 || expq1.size() != 0) begin
            w++;
            if (w > 300) begin
                failNow("idle_timeout");
                return;
            end
            @(negedge clk);
            #2;
        end
    endtask

    // Assert reset asynchronously between edges, drop all requests, and
    // release reset just after the following falling edge.
    task automatic resetPulse();
        #2;
        rst = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #3;
        rst = 1'b0;
    endtask

    // Response-ready generator.
    initial begin : rspReadyGen
        forever begin
            @(negedge clk);
            rsp0_ready = rdyRandom ? ($urandom_range(0, 3) != 0) : rdyForce0;
            rsp1_ready = rdyRandom ? ($urandom_range(0, 3) != 0) : rdyForce1;
        end
    end

    // Monitor and reference model.
    initial begin : monitor
        bit mFree;
        bit mLast;
        bit mId;
        int mAge;
        bit win;
        bit e0;
        bit e1;
        bit eRsp;
        mFree = 1'b1;
        mLast = !PRIO_ID;
        mId   = 1'b0;
        mAge  = 0;
        forever begin
            @(negedge clk or posedge rst);
            #1;
            if (rst) begin
                checkOutput("rst_req0_ready", 64'(req0_ready), 64'd0);
                checkOutput("rst_req1_ready", 64'(req1_ready), 64'd0);
                checkOutput("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
                checkOutput("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
                checkOutput("rst_busy",       64'(busy),       64'd0);
                checkOutput("rst_rsp0_prod",  rsp0_prod,       64'd0);
                checkOutput("rst_rsp1_prod",  rsp1_prod,       64'd0);
                mFree = 1'b1;
                mLast = !PRIO_ID;
                mAge  = 0;
                expq0.delete();
                expq1.delete();
            end else begin
                e0 = 1'b0;
                e1 = 1'b0;
                if (mFree) begin
                    win = (req0_valid && req1_valid) ? !mLast : req1_valid;
                    e0  = req0_valid && !win;
                    e1  = req1_valid &&  win;
                end
                eRsp = !mFree && (mAge >= LAT);
                checkOutput("req0_ready", 64'(req0_ready), 64'(e0));
                checkOutput("req1_ready", 64'(req1_ready), 64'(e1));
                checkOutput("busy",       64'(busy),       64'(!mFree));
                checkOutput("rsp0_valid", 64'(rsp0_valid), 64'(eRsp && !mId));
                checkOutput("rsp1_valid", 64'(rsp1_valid), 64'(eRsp &&  mId));
                if (eRsp && !mId) begin
                    if (expq0.size() == 0) failNow("rsp0_scoreboard_empty");
                    else checkOutput("rsp0_prod", rsp0_prod, expq0[0]);
                end else begin
                    checkOutput("rsp0_prod_idle", rsp0_prod, 64'd0);
                end
                if (eRsp && mId) begin
                    if (expq1.size() == 0) failNow("rsp1_scoreboard_empty");
                    else checkOutput("rsp1_prod", rsp1_prod, expq1[0]);
                end else begin
                    checkOutput("rsp1_prod_idle", rsp1_prod, 64'd0);
                end

                if (e0 || e1) begin
                    mFree = 1'b0;
                    mId   = e1;
                    mLast = e1;
                    mAge  = 1;
                end else if (!mFree) begin
                    if (eRsp && (mId ? rsp1_ready : rsp0_ready)) begin
                        if (mId) begin
                            if (expq1.size() != 0) void'(expq1.pop_front());
                        end else begin
                            if (expq0.size() != 0) void'(expq0.pop_front());
                        end
                        mFree = 1'b1;
                    end else begin
                        mAge++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: actual still running required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        // Reset held over two falling edges, released between edges.
        repeat (2) @(negedge clk);
        #3;
        rst = 1'b0;

        // Single request: 7 x -3 on requester 0.
        applyStimulus(0, 32'd7, 32'hFFFF_FFFD, 0);
        releaseReq(0);
        waitIdle();

        // Corner operands on both requesters.
        applyStimulus(0, 32'h8000_0000, 32'h8000_0000, 0);
        releaseReq(0);
        waitIdle();
        applyStimulus(1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
        releaseReq(1);
        waitIdle();
        applyStimulus(1, 32'h8000_0000, 32'h0000_0001, 0);
        releaseReq(1);
        waitIdle();

        // Contention right after reset: alternating grants starting at PRIO.
        @(posedge clk);
        resetPulse();
        grantLog.delete();
        fork
            begin
                for (int i = 0; i < 2; i++) applyStimulus(0, randOperand(), randOperand(), 0);
                releaseReq(0);
            end
            begin
                for (int i = 0; i < 2; i++) applyStimulus(1, randOperand(), randOperand(), 0);
                releaseReq(1);
            end
        join
        waitIdle();
        if (grantLog.size() != 4) begin
            checkOutput("grant_count", 64'(grantLog.size()), 64'd4);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checkOutput("grant_order", 64'(grantLog[i]), 64'((i % 2 == 0) ? PRIO_ID : !PRIO_ID));
            end
        end

        // Backpressure on requester 1 while requester 0 waits.
        rdyForce1 = 1'b0;
        fork
            begin
                applyStimulus(1, 32'h1234_5678, 32'hDEAD_BEEF, 0);
                releaseReq(1);
            end
            begin
                applyStimulus(0, 32'hFFFF_0001, 32'h0001_FFFF, 2);
                releaseReq(0);
            end
            begin
                int w;
                w = 0;
                @(negedge clk);
                #1;
                while (!rsp1_valid && w < 40) begin
                    w++;
                    @(negedge clk);
                    #1;
                end
                if (!rsp1_valid) failNow("bp_rsp1_valid_timeout");
                repeat (5) @(negedge clk);
                rdyForce1 = 1'b1;
            end
        join
        waitIdle();

        // Randomised traffic with random response backpressure.
        rdyRandom = 1'b1;
        fork
            begin
                for (int i = 0; i < 12; i++) applyStimulus(0, randOperand(), randOperand(), $urandom_range(0, 3));
                releaseReq(0);
            end
            begin
                for (int i = 0; i < 12; i++) applyStimulus(1, randOperand(), randOperand(), $urandom_range(0, 3));
                releaseReq(1);
            end
        join
        rdyRandom = 1'b0;
        waitIdle();

        // Reset in CALC: the in-flight operation vanishes, then a contended
        // request pair goes to PRIO first.
        applyStimulus(1, 32'd1000, 32'd1000, 0);
        resetPulse();
        grantLog.delete();
        fork
            begin
                applyStimulus(0, randOperand(), randOperand(), 0);
                releaseReq(0);
            end
            begin
                applyStimulus(1, randOperand(), randOperand(), 0);
                releaseReq(1);
            end
        join
        waitIdle();
        if (grantLog.size() != 2) begin
            checkOutput("post_reset_grant_count", 64'(grantLog.size()), 64'd2);
        end else begin
            checkOutput("post_reset_first_grant", 64'(grantLog[0]), 64'(PRIO_ID));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
